// File: rtl/uart_bus_master_pkg.sv
// Shared constants, state encodings and helpers for the UART bus master.
// UART_BUS_MASTER_CHECKSUM_EN adds a trailing XOR byte to frames and responses.
package uart_bus_master_pkg;

  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

`ifdef UART_BUS_MASTER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_CHECK, S_BUS, S_RESP
  } state_t;

  typedef enum logic [1:0] {
    R_IDLE, R_SEND, R_GUARD
  } resp_state_t;

  // XOR of the first n bytes of a big-endian word.
  function automatic logic [7:0] xor_bytes(input logic [31:0] w, input logic [2:0] n);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < n) x = x ^ w[31 - 8*i -: 8];
    end
    return x;
  endfunction

endpackage

// File: rtl/uart_bus_master_resp.sv
// Response shifter: holds up to five bytes and paces them onto the UART sender.
// With UART_BUS_MASTER_CHECKSUM_EN an XOR byte follows loads that request it.
module uart_bus_master_resp
  import uart_bus_master_pkg::*;
(
  input  logic        sysclk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_bytes,
  input  logic [2:0]  load_len,
  input  logic        load_csum,
  input  logic        tx_ready,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic        done
);

  resp_state_t rstate, rstate_nx;
  logic [39:0] sbuf, sbuf_ld;
  logic [2:0]  rem, rem_ld;
  logic [7:0]  csum_byte;

  assign csum_byte = xor_bytes(load_bytes, load_len);

  // Checksum byte lands directly behind the last payload byte.
  always_comb begin
    sbuf_ld = {load_bytes, 8'h00};
    rem_ld  = load_len;
    if (CSUM_EN && load_csum) begin
      rem_ld = load_len + 3'd1;
      case (load_len)
        3'd1:    sbuf_ld[31:24] = csum_byte;
        3'd2:    sbuf_ld[23:16] = csum_byte;
        3'd3:    sbuf_ld[15:8]  = csum_byte;
        default: sbuf_ld[7:0]   = csum_byte;
      endcase
    end
  end

  assign tx_en   = (rstate == R_SEND) && tx_ready;
  assign tx_data = tx_en ? sbuf[39:32] : 8'h00;
  assign done    = tx_en && (rem == 3'd1);

  always_comb begin
    rstate_nx = rstate;
    case (rstate)
      R_IDLE:  if (load) rstate_nx = R_SEND;
      R_SEND:  if (tx_ready) rstate_nx = (rem == 3'd1) ? R_IDLE : R_GUARD;
      R_GUARD: rstate_nx = R_SEND;
      default: rstate_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) rstate <= R_IDLE;
    else       rstate <= rstate_nx;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sbuf <= '0;
      rem  <= '0;
    end else if (load) begin
      sbuf <= sbuf_ld;
      rem  <= rem_ld;
    end else if (tx_en) begin
      sbuf <= {sbuf[31:0], 8'h00};
      rem  <= rem - 3'd1;
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// UART-driven debug initiator: decodes read/write frames into single bus accesses.
// UART_BUS_MASTER_CHECKSUM_EN enables XOR-checked frames and responses.
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int TIMEOUT = 1000000
)(
  input  logic        sysclk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy,
  output logic        rx_overrun
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state, state_nx;
  logic            is_wr;
  logic [2:0]      cnt;
  logic [2:0]      data_last;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_hit;
  logic [7:0]      csum;
  logic [31:0]     addr_sr, wdata_sr;
  logic            resp_load, resp_csum, resp_done;
  logic [31:0]     resp_bytes;
  logic [2:0]      resp_len;

  // Reads only pass through DATA when a checksum byte trails the address.
  assign data_last = CSUM_EN ? (is_wr ? 3'd4 : 3'd0) : 3'd3;
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));

  assign rd   = (state == S_BUS) && !is_wr;
  assign wr   = (state == S_BUS) && is_wr;
  assign busy = (state != S_IDLE);

  always_comb begin
    state_nx   = state;
    resp_load  = 1'b0;
    resp_bytes = {RSP_NAK, 24'h000000};
    resp_len   = 3'd1;
    resp_csum  = 1'b0;
    case (state)
      S_IDLE:
        if (rx_valid) begin
          if (rx_data == CMD_RD || rx_data == CMD_WR) begin
            state_nx = S_ADDR;
          end else begin
            state_nx  = S_RESP;
            resp_load = 1'b1;
          end
        end
      S_ADDR:
        if (rx_valid) begin
          if (cnt == 3'd3) state_nx = (is_wr || CSUM_EN) ? S_DATA : S_CHECK;
        end else if (tmo_hit) begin
          state_nx = S_IDLE;
        end
      S_DATA:
        if (rx_valid) begin
          if (cnt == data_last) state_nx = S_CHECK;
        end else if (tmo_hit) begin
          state_nx = S_IDLE;
        end
      S_CHECK:
        if (addr_sr[1:0] != 2'b00 || (CSUM_EN && csum != 8'h00)) begin
          state_nx  = S_RESP;
          resp_load = 1'b1;
        end else begin
          state_nx = S_BUS;
        end
      S_BUS: begin
        state_nx  = S_RESP;
        resp_load = 1'b1;
        resp_csum = 1'b1;
        if (is_wr) begin
          resp_bytes = {RSP_ACK, 24'h000000};
        end else begin
          resp_bytes = rdata;
          resp_len   = 3'd4;
        end
      end
      S_RESP:
        if (resp_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      is_wr      <= 1'b0;
      cnt        <= '0;
      tmo_cnt    <= '0;
      csum       <= '0;
      addr_sr    <= '0;
      wdata_sr   <= '0;
      addr       <= '0;
      wdata      <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_valid && (state == S_CHECK || state == S_BUS || state == S_RESP))
        rx_overrun <= 1'b1;
      case (state)
        S_IDLE:
          if (rx_valid) begin
            is_wr   <= (rx_data == CMD_WR);
            csum    <= rx_data;
            cnt     <= '0;
            tmo_cnt <= '0;
          end
        S_ADDR, S_DATA:
          if (rx_valid) begin
            csum    <= csum ^ rx_data;
            tmo_cnt <= '0;
            cnt     <= (state == S_ADDR && cnt == 3'd3) ? 3'd0 : cnt + 3'd1;
            if (state == S_ADDR)
              addr_sr <= {addr_sr[23:0], rx_data};
            else if (is_wr && cnt < 3'd4)
              wdata_sr <= {wdata_sr[23:0], rx_data};
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        S_CHECK:
          if (state_nx == S_BUS) begin
            addr <= addr_sr;
            if (is_wr) wdata <= wdata_sr;
          end
        default: ;
      endcase
    end
  end

  uart_bus_master_resp u_resp (
    .sysclk     (sysclk),
    .reset      (reset),
    .load       (resp_load),
    .load_bytes (resp_bytes),
    .load_len   (resp_len),
    .load_csum  (resp_csum),
    .tx_ready   (tx_ready),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .done       (resp_done)
  );

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: directed frames plus randomized frames
// scored against a frame-level reference model of the command protocol.
module tb_uart_bus_master;

  localparam int TMO = 64;

  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_ready = 1'b1;
  logic [31:0] rdata = 32'h0;
  logic        tx_en, rd, wr, busy, rx_overrun;
  logic [7:0]  tx_data;
  logic [31:0] addr, wdata;

  uart_bus_master #(.TIMEOUT(TMO)) dut (
    .sysclk(sysclk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_en(tx_en), .tx_data(tx_data), .rd(rd), .wr(wr),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .rx_overrun(rx_overrun)
  );

  always #5 sysclk = ~sysclk;

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  // Bus/UART observation, sampled mid-cycle
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, space_err = 0;
  int bus_cyc = 0, last_tx_cyc = -100;
  logic [31:0] rd_addr = 0, wr_addr = 0, wr_data = 0;
  logic [7:0] txq[$];
  int txc[$];

  always @(negedge sysclk) begin
    if (rd === 1'b1) begin rd_cnt++; rd_addr = addr; bus_cyc = cyc; end
    if (wr === 1'b1) begin wr_cnt++; wr_addr = addr; wr_data = wdata; bus_cyc = cyc; end
    if (rd === 1'b1 && wr === 1'b1) both_cnt++;
    if (tx_en === 1'b1) begin
      txq.push_back(tx_data);
      txc.push_back(cyc);
      if (cyc - last_tx_cyc < 2) space_err++;
      last_tx_cyc = cyc;
    end
  end

  // UART sender model: goes busy the cycle after each strobe for 1..4 cycles
  initial forever begin
    @(negedge sysclk);
    if (tx_en === 1'b1) begin
      @(posedge sysclk); #1 tx_ready = 1'b0;
      repeat (1 + $urandom_range(0, 3)) @(posedge sysclk);
      #1 tx_ready = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Frame under test, model expectations and per-frame snapshots
  logic [7:0]  frm[$];
  logic [7:0]  exp_tx[$];
  logic        exp_rd, exp_wr;
  logic [31:0] exp_addr, exp_wdata;
  int          exp_len;
  logic [63:0] exp_pk;
  int rd0, wr0, tx0, sp0, bo0, last_byte_cyc;
  int          got_len;
  logic [63:0] got_pk;

  task automatic add_csum(input bit corrupt);
    logic [7:0] x;
    x = 8'h00;
    foreach (frm[i]) x ^= frm[i];
    if (corrupt) x ^= 8'($urandom_range(1, 255));
    frm.push_back(x);
  endtask

  // Protocol-level model: what the bus and the UART should see for one frame.
  task automatic model_frame(input logic [31:0] rv);
    logic [7:0] x;
    logic ok;
    exp_rd = 0; exp_wr = 0; exp_tx.delete(); x = 8'h00;
    foreach (frm[i]) x ^= frm[i];
    if (frm[0] == 8'h52 || frm[0] == 8'h57) begin
      exp_addr = {frm[1], frm[2], frm[3], frm[4]};
      ok = (exp_addr % 4 == 0);
`ifdef UART_BUS_MASTER_CHECKSUM_EN
      ok = ok && (x == 8'h00);
`endif
      if (!ok) exp_tx.push_back(8'h15);
      else begin
        if (frm[0] == 8'h52) begin
          exp_rd = 1;
          for (int i = 0; i < 4; i++) exp_tx.push_back(rv[31 - 8*i -: 8]);
        end else begin
          exp_wr = 1;
          exp_wdata = {frm[5], frm[6], frm[7], frm[8]};
          exp_tx.push_back(8'h06);
        end
`ifdef UART_BUS_MASTER_CHECKSUM_EN
        x = 8'h00;
        foreach (exp_tx[i]) x ^= exp_tx[i];
        exp_tx.push_back(x);
`endif
      end
    end else exp_tx.push_back(8'h15);
    exp_len = exp_tx.size();
    exp_pk = 64'h0;
    foreach (exp_tx[i]) exp_pk = {exp_pk[55:0], exp_tx[i]};
  endtask

  task automatic build_random();
    int k;
    logic [31:0] a, d;
    logic [7:0] c;
    k = $urandom_range(0, 3);
    a = $urandom & 32'hFFFF_FFFC;
    d = $urandom;
    c = ($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52;
    if (k == 0) c = 8'h52;
    if (k == 1) c = 8'h57;
    if (k == 2) a = a | 32'($urandom_range(1, 3));
    frm.delete();
    if (k == 3) begin
      c = 8'($urandom);
      if (c == 8'h52 || c == 8'h57) c = 8'h41;
      frm.push_back(c);
      return;
    end
    frm.push_back(c);
    for (int i = 0; i < 4; i++) frm.push_back(a[31 - 8*i -: 8]);
    if (c == 8'h57) for (int i = 0; i < 4; i++) frm.push_back(d[31 - 8*i -: 8]);
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    add_csum($urandom_range(0, 4) == 0);
`endif
  endtask

  task automatic snap();
    rd0 = rd_cnt; wr0 = wr_cnt; tx0 = txq.size(); sp0 = space_err; bo0 = both_cnt;
  endtask

  task automatic send_bytes(input int gap_max);
    int g;
    foreach (frm[i]) begin
      @(posedge sysclk); #1;
      rx_valid = 1'b1; rx_data = frm[i]; last_byte_cyc = cyc;
      g = $urandom_range(0, gap_max);
      if (g > 0) begin
        @(posedge sysclk); #1 rx_valid = 1'b0;
        repeat (g - 1) @(posedge sysclk);
      end
    end
    @(posedge sysclk); #1 rx_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge sysclk);
      if (busy === 1'b0) begin ok = 1; break; end
    end
    repeat (2) @(posedge sysclk);
    #1;
  endtask

  task automatic get_tx();
    got_len = txq.size() - tx0;
    got_pk = 64'h0;
    for (int i = tx0; i < txq.size(); i++) got_pk = {got_pk[55:0], txq[i]};
  endtask

  task automatic do_frame(input int gap_max, output bit ok);
    snap();
    send_bytes(gap_max);
    wait_idle(ok);
    get_tx();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sysclk);
    total++; if ({tx_en, rd, wr, busy, rx_overrun} !== 5'b0) begin bad++;
      $display("FAIL reset_ctrl got=%b want=00000", {tx_en, rd, wr, busy, rx_overrun}); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_txdata got=%h want=00", tx_data); end
    total++; if (addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", addr); end
    total++; if (wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", wdata); end
    @(posedge sysclk); #1 reset = 1'b0;
  endtask

  task automatic test_write();
    bit ok;
    frm = '{8'h57, 8'h40, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'hA5};
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    add_csum(0);
`endif
    model_frame(32'h0);
    do_frame(0, ok);
    total++; if (!ok) begin bad++; $display("FAIL wr_done got=busy want=idle"); end
    total++; if (wr_cnt - wr0 != 1) begin bad++; $display("FAIL wr_pulses got=%0d want=1", wr_cnt - wr0); end
    total++; if (rd_cnt - rd0 != 0) begin bad++; $display("FAIL wr_rd_pulses got=%0d want=0", rd_cnt - rd0); end
    total++; if (wr_addr !== 32'h4000000C) begin bad++; $display("FAIL wr_addr got=%h want=4000000c", wr_addr); end
    total++; if (wr_data !== 32'h000000A5) begin bad++; $display("FAIL wr_wdata got=%h want=000000a5", wr_data); end
    total++; if (bus_cyc - last_byte_cyc != 2) begin bad++;
      $display("FAIL wr_latency got=%0d want=2", bus_cyc - last_byte_cyc); end
    total++; if (got_len != exp_len || got_pk !== exp_pk) begin bad++;
      $display("FAIL wr_tx got=%0d:%h want=%0d:%h", got_len, got_pk, exp_len, exp_pk); end
    total++; if (got_len < 1 || txc[tx0] - last_byte_cyc < 3) begin bad++;
      $display("FAIL wr_tx_latency got=%0d want>=3", (got_len < 1) ? -1 : txc[tx0] - last_byte_cyc); end
  endtask

  task automatic test_read();
    bit ok;
    rdata = 32'h0000005A;
    frm = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h10};
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    add_csum(0);
`endif
    model_frame(rdata);
    do_frame(0, ok);
    total++; if (!ok || rd_cnt - rd0 != 1 || wr_cnt - wr0 != 0) begin bad++;
      $display("FAIL rd_pulses got=rd%0d/wr%0d want=rd1/wr0", rd_cnt - rd0, wr_cnt - wr0); end
    total++; if (rd_addr !== 32'h40000010) begin bad++; $display("FAIL rd_addr got=%h want=40000010", rd_addr); end
    total++; if (got_len != exp_len || got_pk !== exp_pk) begin bad++;
      $display("FAIL rd_tx got=%0d:%h want=%0d:%h", got_len, got_pk, exp_len, exp_pk); end
    total++; if (space_err - sp0 != 0) begin bad++; $display("FAIL rd_tx_spacing got=%0d want=0", space_err - sp0); end
  endtask

  task automatic test_nak();
    bit ok;
    for (int n = 0; n < 2; n++) begin
      if (n == 0) frm = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h02};
      else        frm = '{8'h41};
`ifdef UART_BUS_MASTER_CHECKSUM_EN
      if (n == 0) add_csum(0);
`endif
      do_frame(1, ok);
      total++; if (!ok || rd_cnt - rd0 + wr_cnt - wr0 != 0) begin bad++;
        $display("FAIL nak%0d_bus got=%0d want=0", n, rd_cnt - rd0 + wr_cnt - wr0); end
      total++; if (got_len != 1 || got_pk !== 64'h15) begin bad++;
        $display("FAIL nak%0d_tx got=%0d:%h want=1:15", n, got_len, got_pk); end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    frm = '{8'h57, 8'h40, 8'h00};
    snap();
    send_bytes(0);
    repeat (TMO + 1) @(posedge sysclk);
    @(negedge sysclk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_busy got=%b want=0", busy); end
    get_tx();
    total++; if (rd_cnt - rd0 + wr_cnt - wr0 != 0 || got_len != 0) begin bad++;
      $display("FAIL tmo_silent got=bus%0d/tx%0d want=0/0", rd_cnt - rd0 + wr_cnt - wr0, got_len); end
    rdata = $urandom;
    frm = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h10};
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    add_csum(0);
`endif
    model_frame(rdata);
    do_frame(0, ok);
    total++; if (!ok || rd_cnt - rd0 != 1 || got_pk !== exp_pk || got_len != exp_len) begin bad++;
      $display("FAIL tmo_recover got=rd%0d tx=%h want=rd1 tx=%h", rd_cnt - rd0, got_pk, exp_pk); end
  endtask

  task automatic test_overrun();
    bit ok;
    int k;
    total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL ovr_initial got=%b want=0", rx_overrun); end
    rdata = $urandom;
    frm = '{8'h52, 8'h12, 8'h34, 8'h56, 8'h78};
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    add_csum(0);
`endif
    model_frame(rdata);
    snap();
    send_bytes(0);
    for (k = 0; k < 100 && txq.size() == tx0; k++) @(negedge sysclk);
    @(posedge sysclk); #1 rx_valid = 1'b1; rx_data = 8'h52;
    @(posedge sysclk); #1 rx_valid = 1'b0;
    wait_idle(ok);
    get_tx();
    total++; if (rx_overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b want=1", rx_overrun); end
    total++; if (!ok || rd_cnt - rd0 != 1 || got_len != exp_len || got_pk !== exp_pk) begin bad++;
      $display("FAIL ovr_resp got=rd%0d %0d:%h want=rd1 %0d:%h", rd_cnt - rd0, got_len, got_pk, exp_len, exp_pk); end
  endtask

  task automatic test_reset_resp();
    int k;
    rdata = $urandom;
    frm = '{8'h52, 8'h00, 8'h00, 8'h01, 8'h00};
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    add_csum(0);
`endif
    snap();
    send_bytes(0);
    for (k = 0; k < 100 && txq.size() == tx0; k++) @(negedge sysclk);
    #2 reset = 1'b1;
    #1;
    total++; if ({tx_en, rd, wr, busy, rx_overrun} !== 5'b0 || tx_data !== 8'h00) begin bad++;
      $display("FAIL rst_mid_ctrl got=%b/%h want=00000/00", {tx_en, rd, wr, busy, rx_overrun}, tx_data); end
    total++; if (addr !== 32'h0 || wdata !== 32'h0) begin bad++;
      $display("FAIL rst_mid_bus got=%h/%h want=0/0", addr, wdata); end
    @(posedge sysclk); #1 reset = 1'b0;
    repeat (6) @(posedge sysclk);
    #1;
  endtask

  task automatic test_random(input int n, input int gap_max);
    bit ok;
    for (int f = 0; f < n; f++) begin
      build_random();
      rdata = $urandom;
      model_frame(rdata);
      do_frame(gap_max, ok);
      total++; if (!ok) begin bad++; $display("FAIL rnd%0d_done got=busy want=idle", f); end
      total++; if (rd_cnt - rd0 != int'(exp_rd) || wr_cnt - wr0 != int'(exp_wr)) begin bad++;
        $display("FAIL rnd%0d_bus got=rd%0d/wr%0d want=rd%0d/wr%0d", f, rd_cnt - rd0, wr_cnt - wr0, exp_rd, exp_wr); end
      if (exp_rd) begin
        total++; if (rd_addr !== exp_addr) begin bad++; $display("FAIL rnd%0d_raddr got=%h want=%h", f, rd_addr, exp_addr); end
      end
      if (exp_wr) begin
        total++; if (wr_addr !== exp_addr || wr_data !== exp_wdata) begin bad++;
          $display("FAIL rnd%0d_write got=%h/%h want=%h/%h", f, wr_addr, wr_data, exp_addr, exp_wdata); end
      end
      total++; if (got_len != exp_len || got_pk !== exp_pk) begin bad++;
        $display("FAIL rnd%0d_tx got=%0d:%h want=%0d:%h", f, got_len, got_pk, exp_len, exp_pk); end
      total++; if (space_err - sp0 != 0 || both_cnt - bo0 != 0) begin bad++;
        $display("FAIL rnd%0d_proto got=sp%0d/both%0d want=0/0", f, space_err - sp0, both_cnt - bo0); end
    end
  endtask

  task automatic test_back_to_back();
    test_random(12, 0);
  endtask

`ifdef UART_BUS_MASTER_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    rdata = $urandom;
    frm = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h10, 8'h02};
    model_frame(rdata);
    do_frame(0, ok);
    total++; if (!ok || rd_cnt - rd0 != 1 || got_len != 5 || got_pk !== exp_pk) begin bad++;
      $display("FAIL csum_good got=rd%0d %0d:%h want=rd1 5:%h", rd_cnt - rd0, got_len, got_pk, exp_pk); end
    frm = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h10, 8'h03};
    do_frame(0, ok);
    total++; if (!ok || rd_cnt - rd0 != 0 || got_len != 1 || got_pk !== 64'h15) begin bad++;
      $display("FAIL csum_bad got=rd%0d %0d:%h want=rd0 1:15", rd_cnt - rd0, got_len, got_pk); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nak();
    test_timeout();
    test_overrun();
    test_reset_resp();
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    test_checksum();
`endif
    test_random(30, 2);
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

Serial-to-bus debug initiator: it is the initiator end of the memory-mapped peripheral bus (`rd`/`wr`/`addr`/`wdata`/`rdata`) that the peripheral block responds to. It consumes received bytes from a UART receiver, decodes fixed-format read/write command frames, issues single-cycle bus accesses, and returns response bytes through a UART sender handshake. It sits beside the CPU as a host-side loader and inspection path, muxed onto the peripheral bus while `busy` is high.

## Interface
- `TIMEOUT`, 1000000: inter-byte timeout in `sysclk` cycles while a frame is partially received.
- `sysclk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `rx_valid` in 1: one-cycle strobe, `rx_data` holds a received byte.
- `rx_data` in 8: received byte.
- `tx_ready` in 1: sender idle (level).
- `tx_en` out 1: one-cycle send strobe.
- `tx_data` out 8: byte to send, valid while `tx_en`=1.
- `rd` out 1: bus read strobe.
- `wr` out 1: bus write strobe.
- `addr` out 32: bus address.
- `wdata` out 32: bus write data.
- `rdata` in 32: bus read data, combinational from the responder.
- `busy` out 1: frame in progress (any state but IDLE).
- `rx_overrun` out 1: sticky; byte arrived while not receiving. Cleared only by reset.

## Operation
- Reset values: all outputs 0; state IDLE; counters 0.
- Frames, multi-byte fields big-endian:
  - Read: `0x52`, A3 A2 A1 A0. Response: D3 D2 D1 D0.
  - Write: `0x57`, A3..A0, D3..D0. Response: `0x06`.
- States:
  - IDLE: on `rx_valid`, `0x52`/`0x57` → ADDR. Any other byte → RESP with single `0x15` (NAK).
  - ADDR: collects 4 bytes. Read → CHECK. Write → DATA.
  - DATA: collects 4 bytes → CHECK.
  - CHECK: `addr[1:0]`≠0 → NAK, no bus access. Otherwise → BUS.
  - BUS: one cycle. `rd` or `wr`=1. `rdata` is captured into the response shifter at the end of that cycle → RESP.
  - RESP: sends bytes one at a time: pulse `tx_en` when `tx_ready`=1, one guard cycle, then wait for `tx_ready`=1 again. After the last byte → IDLE.
- Bytes arriving in CHECK/BUS/RESP are dropped and set `rx_overrun`.
- Timeout counter reloads on every accepted byte in ADDR/DATA. Reaching `TIMEOUT` discards the frame silently → IDLE. No bus access, no response.
- `addr`/`wdata` hold their last values outside BUS. `rd` and `wr` are never high together.
- Reset mid-frame or mid-response aborts immediately. No partial bus access survives, and a pending `tx_en` is dropped.

## Timing
- Last frame byte at cycle N: CHECK at N+1, `rd`/`wr` at N+2.
- First `tx_en` at N+3 earliest, if `tx_ready`=1.
- Minimum spacing between consecutive `tx_en` pulses: 2 cycles. The sender must drop `tx_ready` within one cycle of `tx_en`.
- `rx_valid` is accepted on any cycle in IDLE/ADDR/DATA. Back-to-back strobes are legal.

## Configuration
- `UART_BUS_MASTER_CHECKSUM_EN` defined:
  - Each command frame carries a trailing byte, the XOR of all preceding frame bytes.
  - A mismatch gives NAK `0x15` with no bus access.
  - Every response (including ACK; excluding NAK) is followed by its own XOR byte.
- Undefined: no checksum byte in either direction.

## Structure
- `uart_bus_master_pkg`:
  - Command constants `CMD_RD`=`0x52`, `CMD_WR`=`0x57`.
  - Response constants `RSP_ACK`=`0x06`, `RSP_NAK`=`0x15`.
  - State enum.
- One sub-module, `uart_bus_master_resp`: loads up to 5 bytes plus a length, and owns the `tx_en`/`tx_ready` handshake and the response checksum.

## Test plan
- Write: `57 40 00 00 0C 00 00 00 A5` → exactly one cycle `wr`=1, `addr`=`0x4000000C`, `wdata`=`0x000000A5`; tx `06`.
- Read: `52 40 00 00 10` with `rdata`=`0x0000005A` → one cycle `rd`=1; tx `00 00 00 5A`; `tx_en` pulses at least 2 cycles apart.
- Misaligned `52 40 00 00 02`, and unknown byte `41` → no `rd`/`wr`; tx `15` each time.
- Timeout: `57 40 00`, then silence for `TIMEOUT`+1 cycles → no bus access, no tx. A following valid read frame completes normally.
- `rx_valid` pulsed during RESP → `rx_overrun`=1, and the response is unchanged. Reset asserted mid-RESP → all outputs 0, `busy`=0, `rx_overrun`=0.
- With the macro defined: `52 40 00 00 10 02` (correct XOR) → data plus XOR byte. Same frame with final byte `03` → `15`, no `rd`.
